share_seq_adder: RTL and testbench

SHARE_SEQ_ADDER -- requirements
Module: share_seq_adder

---
 rtl/share_seq_adder.sv | 138 +++++++++++++
 tb/tb_share_seq_adder.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/share_seq_adder.sv
// share_seq_adder
//   Computes z = k + 2*s with s = x ? w : v, using a single W+2-bit adder
//   that is reused over two consecutive cycles (k+s, then +s again).
//   A simple valid/ready handshake on the input and output sides.
//
// Build option:
//   SHARE_SAT_EN - when defined, z saturates to 2^(W+1)-1.
//                  Otherwise z carries the full W+2-bit sum.
//
// Ports:
//   clk       - rising-edge clock
//   rst_n     - asynchronous active-low reset
//   in_valid  - operand set on k/v/w/x is valid
//   in_ready  - block can accept an operand set (IDLE only)
//   k, v, w   - unsigned W-bit operands
//   x         - operand select (1: w, 0: v)
//   z         - W+2-bit result, meaningful while out_valid=1
//   out_valid - z holds a result
//   out_ready - consumer accepts z
//   op_cnt    - count of completed transfers, wraps at 256
//
// state | meaning
// IDLE  | waiting for an operand set, in_ready=1
// ADD1  | acc <= k + s
// ADD2  | acc <= acc + s
// DONE  | result presented, waiting for out_ready
module share_seq_adder #(
  parameter int W = 3
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [W-1:0]   k,
  input  logic [W-1:0]   v,
  input  logic [W-1:0]   w,
  input  logic           x,
  output logic [W+1:0]   z,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [7:0]     op_cnt
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD1 = 2'd1,
    ADD2 = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t         state;
  state_t         state_nxt;

  logic [W-1:0]   k_q;
  logic [W-1:0]   s_q;
  logic [W+1:0]   acc;
  logic [W+1:0]   add_a;
  logic [W+1:0]   add_b;
  logic [W+1:0]   sum;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state, handshake outputs and adder operand mux
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    add_a     = acc;
    add_b     = {2'b00, s_q};
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = ADD1;
      end
      ADD1: begin
        add_a     = {2'b00, k_q};
        state_nxt = ADD2;
      end
      ADD2: begin
        state_nxt = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        // Always return to IDLE first; no accept in the consume cycle.
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // The one shared adder
  assign sum = add_a + add_b;

  // Operand capture and accumulator
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      k_q <= '0;
      s_q <= '0;
      acc <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            k_q <= k;
            s_q <= x ? w : v;
          end
        end
        ADD1:    acc <= sum;
        ADD2:    acc <= sum;
        default: ;
      endcase
    end
  end

  // Completed-transfer counter, wraps naturally at 8 bits
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_cnt <= '0;
    end else if (state == DONE && out_ready) begin
      op_cnt <= op_cnt + 8'd1;
    end
  end

`ifdef SHARE_SAT_EN
  localparam logic [W+1:0] SAT_MAX = {2'b01, {W{1'b1}}};
  assign z = (acc > SAT_MAX) ? SAT_MAX : acc;
`else
  assign z = acc;
`endif

endmodule

// File: tb/tb_share_seq_adder.sv
module tb_share_seq_adder;
  localparam int W = 3;
  localparam int ZMAX = (1 << (W + 1)) - 1;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           in_valid = 1'b0;
  logic           in_ready;
  logic [W-1:0]   k = '0;
  logic [W-1:0]   v = '0;
  logic [W-1:0]   w = '0;
  logic           x = 1'b0;
  logic [W+1:0]   z;
  logic           out_valid;
  logic           out_ready = 1'b0;
  logic [7:0]     op_cnt;

  int checks = 0;
  int errors = 0;

  share_seq_adder #(.W(W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .k(k), .v(v), .w(w), .x(x), .z(z), .out_valid(out_valid),
    .out_ready(out_ready), .op_cnt(op_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int expect_z(input int kk, input int vv, input int ww, input bit xx);
    int r;
    r = kk + 2 * (xx ? ww : vv);
`ifdef SHARE_SAT_EN
    if (r > ZMAX) r = ZMAX;
`endif
    return r;
  endfunction

  // Transaction-level reference: a result is owed three edges after the
  // accepting edge and is retired by the first edge that sees out_ready.
  int   cyc;
  int   m_acc_cyc;
  bit   m_busy;
  int   m_z;
  int   m_opcnt;
  wire  m_ov = m_busy && ((cyc - m_acc_cyc) >= 3);

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cyc       <= 0;
      m_busy    <= 1'b0;
      m_acc_cyc <= 0;
      m_z       <= 0;
      m_opcnt   <= 0;
    end else begin
      cyc <= cyc + 1;
      if (!m_busy) begin
        if (in_valid) begin
          m_busy    <= 1'b1;
          m_acc_cyc <= cyc;
          m_z       <= expect_z(int'(k), int'(v), int'(w), x);
        end
      end else if (m_ov && out_ready) begin
        m_busy  <= 1'b0;
        m_opcnt <= (m_opcnt + 1) % 256;
      end
    end
  end

  // Cycle-by-cycle comparison against the reference
  always @(negedge clk) begin
    if (rst_n) begin
      check("model_in_ready", int'(in_ready), int'(!m_busy));
      check("model_out_valid", int'(out_valid), int'(m_ov));
      if (m_ov) check("model_z", int'(z), m_z);
      check("model_op_cnt", int'(op_cnt), m_opcnt);
    end
  end

  task automatic send(input int kk, input int vv, input int ww, input bit xx);
    @(negedge clk);
    in_valid = 1'b1;
    k = kk[W-1:0]; v = vv[W-1:0]; w = ww[W-1:0]; x = xx;
    @(negedge clk);
    in_valid = 1'b0;
    // Scramble operands after acceptance; the result must not move.
    k = W'($urandom); v = W'($urandom); w = W'($urandom); x = 1'($urandom);
  endtask

  task automatic wait_valid();
    int n;
    n = 0;
    while (!out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!out_valid) check("wait_valid_timeout", 0, 1);
  endtask

  task automatic consume();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("rst_in_ready", int'(in_ready), 1);
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_z", int'(z), 0);
    check("rst_op_cnt", int'(op_cnt), 0);
    @(negedge clk);
    #2 rst_n = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int seen;
    int last;
    int ncyc;
    bit saw255;

    // Reset state
    #3;
    do_reset();

    // k=3 w=5 x=1 -> 13, valid after the second edge following acceptance
    send(3, 2, 5, 1);
    check("lat_n0_out_valid", int'(out_valid), 0);
    @(negedge clk);
    check("lat_n1_out_valid", int'(out_valid), 0);
    @(negedge clk);
    check("lat_n2_out_valid", int'(out_valid), 1);
    check("s1_z", int'(z), 13);
    consume();
    check("s1_op_cnt", int'(op_cnt), 1);
    check("s1_idle_out_valid", int'(out_valid), 0);

    // Largest operands: 21 unsaturated, 15 saturated
    send(7, 0, 7, 1);
    wait_valid();
`ifdef SHARE_SAT_EN
    check("s2_z_sat", int'(z), 15);
`else
    check("s2_z_full", int'(z), 21);
`endif
    consume();
    check("s2_op_cnt", int'(op_cnt), 2);

    // x=0 path plus stall with toggling inputs
    send(2, 1, 6, 0);
    wait_valid();
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      k = W'($urandom); v = W'($urandom); w = W'($urandom); x = 1'($urandom);
      @(negedge clk);
      check("stall_z", int'(z), 4);
      check("stall_in_ready", int'(in_ready), 0);
      check("stall_out_valid", int'(out_valid), 1);
    end
    // Consume while in_valid is high: IDLE must be entered before any accept
    out_ready = 1'b1;
    @(negedge clk);
    check("no_same_cycle_accept", int'(in_ready), 1);
    check("s3_op_cnt", int'(op_cnt), 3);
    in_valid = 1'b0;
    out_ready = 1'b0;

    // out_ready asserted while idle does nothing
    out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    check("idle_ready_op_cnt", int'(op_cnt), 3);

    // Abort in ADD2 via reset
    send(1, 4, 0, 0);
    @(negedge clk);          // now in ADD2
    #2 rst_n = 1'b0;
    #1;
    check("abort_out_valid", int'(out_valid), 0);
    check("abort_z", int'(z), 0);
    check("abort_op_cnt", int'(op_cnt), 0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    send(0, 1, 0, 0);
    wait_valid();
    check("after_abort_z", int'(z), 2);
    consume();
    check("after_abort_op_cnt", int'(op_cnt), 1);

    // 256 back-to-back transfers with out_ready tied high
    do_reset();
    in_valid = 1'b1;
    out_ready = 1'b1;
    seen = 0;
    last = 0;
    ncyc = 0;
    saw255 = 1'b0;
    while (seen < 256 && ncyc < 2000) begin
      k = W'($urandom); v = W'($urandom); w = W'($urandom); x = 1'($urandom);
      @(negedge clk);
      ncyc++;
      if (op_cnt == 8'd255) saw255 = 1'b1;
      if (out_valid) begin
        if (seen > 0) check("b2b_interval", ncyc - last, 4);
        last = ncyc;
        seen++;
      end
    end
    in_valid = 1'b0;
    check("b2b_count", seen, 256);
    @(negedge clk);
    out_ready = 1'b0;
    check("b2b_saw_255", int'(saw255), 1);
    check("b2b_wrap_op_cnt", int'(op_cnt), 0);
    check("b2b_idle", int'(in_ready), 1);

    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
